// File: rtl/alpha_blend_pkg.sv
// alpha_blend_pkg: shared types and fixed-point helpers for alpha_blend_pipe.
//   blend_mode_e : per-beat blend mode codes (110/111 are passthrough).
//   q_one        : fixed-point 1.0 for a given fraction width.
//   round_shift  : round-half-up arithmetic right shift by frac_bits.
//   sat_clamp    : clamp to [0, ONE].
// Helpers use a 64-bit signed carrier, so lanes need 2*W+2 <= 64.
package alpha_blend_pkg;

  typedef enum logic [2:0] {
    DISABLED = 3'b000,
    ADD      = 3'b001,
    SUB      = 3'b010,
    BLEND    = 3'b011,
    MUL      = 3'b100,
    PREMUL   = 3'b101
  } blend_mode_e;

  function automatic longint q_one(input int unsigned frac_bits);
    return 64'sd1 <<< frac_bits;
  endfunction

  function automatic longint round_shift(input longint x, input int unsigned frac_bits);
    return (x + (q_one(frac_bits) >>> 1)) >>> frac_bits;
  endfunction

  function automatic longint sat_clamp(input longint x, input int unsigned frac_bits);
    if (x < 64'sd0) return 64'sd0;
    if (x > q_one(frac_bits)) return q_one(frac_bits);
    return x;
  endfunction

endpackage

// File: rtl/alpha_blend_lane.sv
// alpha_blend_lane: one colour channel of the blend datapath.
//   clk, rst  : clock, synchronous active-high reset (output register only)
//   adv       : global pipeline advance enable
//   src, dst  : S1 colour operands (signed Q format)
//   alpha     : S1 clamped alpha, inv_alpha : S1 ONE - alpha
//   mode_sum  : mode aligned with the product registers
//   mode_out  : mode aligned with the pre-saturation register
//   res       : registered blended channel
module alpha_blend_lane
  import alpha_blend_pkg::*;
#(
  parameter int unsigned INT_BITS  = 4,
  parameter int unsigned FRAC_BITS = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                adv,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] src,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] dst,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] alpha,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] inv_alpha,
  input  logic [2:0]                          mode_sum,
  input  logic [2:0]                          mode_out,
  output logic [INT_BITS+FRAC_BITS-1:0]       res
);

  localparam int unsigned W  = INT_BITS + FRAC_BITS;
  localparam int unsigned P  = 2 * W;
  localparam int unsigned PW = 2 * W + 2;

  logic signed [P-1:0]  p_src_a, p_dst_ia, p_src_dst;
  logic signed [W-1:0]  src_s2, dst_s2;
  logic signed [PW-1:0] pre_s3;
  longint               pre_next;
  longint               sat_val;
  logic [W-1:0]         res_next;

  // S2: products
  always_ff @(posedge clk) begin
    if (adv) begin
      p_src_a   <= P'(src) * P'(alpha);
      p_dst_ia  <= P'(dst) * P'(inv_alpha);
      p_src_dst <= P'(src) * P'(dst);
      src_s2    <= src;
      dst_s2    <= dst;
    end
  end

  // S3a: per-mode sum with rounding; saturation is deferred to the output register
  always_comb begin
    pre_next = 64'(src_s2);
    case (mode_sum)
      ADD:     pre_next = 64'(src_s2) + 64'(dst_s2);
      SUB:     pre_next = 64'(src_s2) - 64'(dst_s2);
      BLEND:   pre_next = round_shift(64'(p_src_a) + 64'(p_dst_ia), FRAC_BITS);
      MUL:     pre_next = round_shift(64'(p_src_dst), FRAC_BITS);
      PREMUL:  pre_next = 64'(src_s2) + round_shift(64'(p_dst_ia), FRAC_BITS);
      default: pre_next = 64'(src_s2);
    endcase
  end

  always_ff @(posedge clk) begin
    if (adv) pre_s3 <= PW'(pre_next);
  end

  // S3b: saturate every arithmetic mode; DISABLED and 110/111 pass src raw
  always_comb begin
    sat_val  = sat_clamp(64'(pre_s3), FRAC_BITS);
    res_next = pre_s3[W-1:0];
    if (mode_out inside {ADD, SUB, BLEND, MUL, PREMUL}) res_next = sat_val[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)      res <= '0;
    else if (adv) res <= res_next;
  end

endmodule

// File: rtl/alpha_blend_pipe.sv
// alpha_blend_pipe: pipelined ready/valid alpha blender, latency 3 edges
// after the accepting edge.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_src, in_dst      : CHANNELS x W colour, channel 0 in the MSBs
//   in_alpha            : signed source alpha (clamped to [0, ONE])
//   in_mode             : blend mode (blend_mode_e code)
//   in_tag              : sideband tag carried with the beat
//   out_valid/out_ready : output handshake
//   out_rgb, out_tag    : blended colour and its tag
module alpha_blend_pipe
  import alpha_blend_pkg::*;
#(
  parameter int unsigned INT_BITS  = 4,
  parameter int unsigned FRAC_BITS = 12,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned TAG_W     = 32
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [CHANNELS*(INT_BITS+FRAC_BITS)-1:0]     in_src,
  input  logic [INT_BITS+FRAC_BITS-1:0]                in_alpha,
  input  logic [CHANNELS*(INT_BITS+FRAC_BITS)-1:0]     in_dst,
  input  logic [2:0]                                   in_mode,
  input  logic [TAG_W-1:0]                             in_tag,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [CHANNELS*(INT_BITS+FRAC_BITS)-1:0]     out_rgb,
  output logic [TAG_W-1:0]                             out_tag
);

  localparam int unsigned W = INT_BITS + FRAC_BITS;
  localparam logic signed [W-1:0] ONE = W'(q_one(FRAC_BITS));

  logic adv;
  logic signed [W-1:0] alpha_cl;

  logic [CHANNELS*W-1:0] src_s1, dst_s1;
  logic signed [W-1:0]   a_s1, ia_s1;
  logic [2:0]            mode_s1, mode_s2, mode_s3;
  logic [TAG_W-1:0]      tag_s1, tag_s2, tag_s3;
  logic                  v1, v2, v3;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  always_comb begin
    alpha_cl = signed'(in_alpha);
    if (in_alpha[W-1])                alpha_cl = '0;
    else if (signed'(in_alpha) > ONE) alpha_cl = ONE;
  end

  // S1 operand registers
  always_ff @(posedge clk) begin
    if (adv) begin
      src_s1  <= in_src;
      dst_s1  <= in_dst;
      a_s1    <= alpha_cl;
      ia_s1   <= ONE - alpha_cl;
      mode_s1 <= in_mode;
      tag_s1  <= in_tag;
      mode_s2 <= mode_s1;
      tag_s2  <= tag_s1;
      mode_s3 <= mode_s2;
      tag_s3  <= tag_s2;
    end
  end

  // S3 is split into a sum register and the output register, giving the
  // three-edge latency after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      out_tag   <= tag_s3;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam int unsigned HI = (CHANNELS - c) * W - 1;
    alpha_blend_lane #(
      .INT_BITS (INT_BITS),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .src      (src_s1[HI -: W]),
      .dst      (dst_s1[HI -: W]),
      .alpha    (a_s1),
      .inv_alpha(ia_s1),
      .mode_sum (mode_s2),
      .mode_out (mode_s3),
      .res      (out_rgb[HI -: W])
    );
  end

endmodule
